// File: rtl/ysyx_22040895_mem_resp_if.sv
// Data-memory request/response bundle between the load/store unit (master)
// and the memory responder (slave).
interface ysyx_22040895_mem_resp_if;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_we_i;
    logic [63:0] req_addr_i;
    logic [63:0] req_wdata_i;
    logic [7:0]  req_wmask_i;
    logic        resp_valid_o;
    logic        resp_ready_i;
    logic [63:0] resp_rdata_o;
    logic        resp_err_o;

    modport master (
        output req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_wmask_i,
        output resp_ready_i,
        input  req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o
    );

    modport slave (
        input  req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_wmask_i,
        input  resp_ready_i,
        output req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o
    );
endinterface

// File: rtl/ysyx_22040895_mem_resp.sv
// Memory responder: accepts one request at a time, waits LATENCY cycles,
// then performs a byte-masked write or a full-doubleword read against an
// internal array and holds the response until the initiator takes it.
module ysyx_22040895_mem_resp #(
    parameter logic [63:0] BASE       = 64'h8000_0000,
    parameter int          DEPTH_LOG2 = 10,
    parameter int          LATENCY    = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    ysyx_22040895_mem_resp_if.slave       bus
);
    // A zero-latency build has no wait state, but still needs a legal vector.
    localparam int          CNT_W = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;
    localparam int          DEPTH = 1 << DEPTH_LOG2;
    localparam logic [63:0] SPAN  = 64'(DEPTH) << 3;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic               enter_resp;

    logic               we_reg;
    logic [63:0]        addr_reg;
    logic [63:0]        wdata_reg;
    logic [7:0]         wmask_reg;

    logic [63:0]        rdata_reg;
    logic               err_reg;

    logic [63:0]        mem [DEPTH];

    // Access operands: with no wait state the access happens on the accept
    // edge itself, so the live request is used instead of the latched copy.
    logic               acc_we;
    logic [63:0]        acc_addr;
    logic [63:0]        acc_wdata;
    logic [7:0]         acc_wmask;
    logic [63:0]        acc_off;
    logic               acc_in_range;
    logic [DEPTH_LOG2-1:0] acc_idx;
    logic               mem_we;

    assign acc_we       = (state_reg == S_IDLE) ? bus.req_we_i    : we_reg;
    assign acc_addr     = (state_reg == S_IDLE) ? bus.req_addr_i  : addr_reg;
    assign acc_wdata    = (state_reg == S_IDLE) ? bus.req_wdata_i : wdata_reg;
    assign acc_wmask    = (state_reg == S_IDLE) ? bus.req_wmask_i : wmask_reg;
    assign acc_off      = acc_addr - BASE;
    assign acc_in_range = (acc_addr >= BASE) && (acc_off < SPAN);
    assign acc_idx      = acc_off[DEPTH_LOG2+2:3];
    // Gate with reset so nothing commits while reset is held.
    assign mem_we       = enter_resp && acc_we && acc_in_range && rst;

    assign bus.req_ready_o  = (state_reg == S_IDLE);
    assign bus.resp_valid_o = (state_reg == S_RESP);
    assign bus.resp_rdata_o = rdata_reg;
    assign bus.resp_err_o   = err_reg;

    // Next-state and wait-counter logic.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        enter_resp = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (bus.req_valid_i) begin
                    cnt_next = CNT_W'(LATENCY);
                    if (LATENCY == 0) begin
                        state_next = S_RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_next = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                cnt_next = cnt_reg - 1'b1;
                if (cnt_reg == CNT_W'(1)) begin
                    state_next = S_RESP;
                    enter_resp = 1'b1;
                end
            end
            S_RESP: begin
                if (bus.resp_ready_i) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= S_IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Capture the request on the accept edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            we_reg    <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            wmask_reg <= '0;
        end else if (state_reg == S_IDLE && bus.req_valid_i) begin
            we_reg    <= bus.req_we_i;
            addr_reg  <= bus.req_addr_i;
            wdata_reg <= bus.req_wdata_i;
            wmask_reg <= bus.req_wmask_i;
        end
    end

    // Response registers, loaded on the edge that enters RESP and frozen after.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata_reg <= '0;
            err_reg   <= 1'b0;
        end else if (enter_resp) begin
            if (!acc_in_range) begin
                rdata_reg <= '0;
                err_reg   <= 1'b1;
            end else if (acc_we) begin
                rdata_reg <= '0;
                err_reg   <= 1'b0;
            end else begin
                rdata_reg <= mem[acc_idx];
                err_reg   <= 1'b0;
            end
        end
    end

    // Byte-lane writes into the unreset storage array.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 8; b++) begin
                if (acc_wmask[b]) mem[acc_idx][8*b +: 8] <= acc_wdata[8*b +: 8];
            end
        end
    end
endmodule

// File: tb/tb_ysyx_22040895_mem_resp.sv
// Directed bench: LATENCY=2 responder for functional cases, LATENCY=0
// responder for the streaming case.
module tb_ysyx_22040895_mem_resp;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ysyx_22040895_mem_resp_if bus_a();
    ysyx_22040895_mem_resp_if bus_b();

    ysyx_22040895_mem_resp #(.BASE(64'h8000_0000), .DEPTH_LOG2(10), .LATENCY(2))
        dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    ysyx_22040895_mem_resp #(.BASE(64'h8000_0000), .DEPTH_LOG2(10), .LATENCY(0))
        dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Full transaction on the LATENCY=2 responder with resp_ready held 1.
    task automatic xact_a(input logic we, input logic [63:0] addr, input logic [63:0] wdata,
                          input logic [7:0] wmask, output logic [63:0] rdata,
                          output logic err, output int lat);
        int guard;
        @(negedge clk);
        bus_a.req_valid_i = 1'b1;
        bus_a.req_we_i    = we;
        bus_a.req_addr_i  = addr;
        bus_a.req_wdata_i = wdata;
        bus_a.req_wmask_i = wmask;
        guard = 0;
        while (!bus_a.req_ready_o && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("accept_wait", 64'(guard < 50), 64'd1);
        @(posedge clk);
        #1 bus_a.req_valid_i = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!bus_a.resp_valid_o && lat < 50);
        rdata = bus_a.resp_rdata_o;
        err   = bus_a.resp_err_o;
        $display("[TB] xact we=%0b addr=%h wdata=%h mask=%h -> rdata=%h err=%0b lat=%0d",
                 we, addr, wdata, wmask, rdata, err, lat);
        @(posedge clk);
        #1;
    endtask

    logic [63:0] rd;
    logic        er;
    int          lat;
    int          guard;
    int          acc_cyc, prev_cyc;
    logic [63:0] bexp [4];

    initial begin
        bus_a.req_valid_i = 0; bus_a.req_we_i = 0; bus_a.req_addr_i = '0;
        bus_a.req_wdata_i = '0; bus_a.req_wmask_i = '0; bus_a.resp_ready_i = 1;
        bus_b.req_valid_i = 0; bus_b.req_we_i = 0; bus_b.req_addr_i = '0;
        bus_b.req_wdata_i = '0; bus_b.req_wmask_i = '0; bus_b.resp_ready_i = 1;
        bexp[0] = 64'hA0A0_0000_0000_0001; bexp[1] = 64'hB1B1_0000_0000_0002;
        bexp[2] = 64'hC2C2_0000_0000_0003; bexp[3] = 64'hD3D3_0000_0000_0004;

        repeat (2) @(negedge clk);
        check("rst_ready", 64'(bus_a.req_ready_o), 64'd1);
        check("rst_valid", 64'(bus_a.resp_valid_o), 64'd0);
        check("rst_rdata", bus_a.resp_rdata_o, 64'd0);
        check("rst_err", 64'(bus_a.resp_err_o), 64'd0);

        dut_a.mem[0]    = 64'h1122_3344_5566_7788;
        dut_a.mem[1]    = 64'h0;
        dut_a.mem[2]    = 64'h0123_4567_89AB_CDEF;
        dut_a.mem[5]    = 64'h0;
        dut_a.mem[1023] = 64'hCAFE_F00D_1234_5678;
        for (int i = 0; i < 4; i++) dut_b.mem[i] = bexp[i];
        rst = 1'b1;

        // Basic read and latency.
        xact_a(1'b0, 64'h8000_0000, 64'h0, 8'h00, rd, er, lat);
        check("rd0_data", rd, 64'h1122_3344_5566_7788);
        check("rd0_err", 64'(er), 64'd0);
        check("rd0_lat", 64'(lat), 64'd3);
        xact_a(1'b0, 64'h8000_0005, 64'h0, 8'h00, rd, er, lat);
        check("rd_offs_data", rd, 64'h1122_3344_5566_7788);

        // Masked writes.
        xact_a(1'b1, 64'h8000_0008, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, rd, er, lat);
        check("wr1_rdata", rd, 64'h0);
        check("wr1_err", 64'(er), 64'd0);
        xact_a(1'b0, 64'h8000_0008, 64'h0, 8'h00, rd, er, lat);
        check("wr1_readback", rd, 64'h0000_0000_FFFF_FFFF);
        xact_a(1'b1, 64'h8000_0010, 64'hFFFF_FFFF_FFFF_FFFF, 8'hA5, rd, er, lat);
        xact_a(1'b0, 64'h8000_0010, 64'h0, 8'h00, rd, er, lat);
        check("wr2_readback", rd, 64'hFF23_FF67_89FF_CDFF);
        xact_a(1'b1, 64'h8000_0000, 64'h0, 8'h00, rd, er, lat);
        check("wr0mask_err", 64'(er), 64'd0);
        xact_a(1'b0, 64'h8000_0000, 64'h0, 8'h00, rd, er, lat);
        check("wr0mask_keep", rd, 64'h1122_3344_5566_7788);

        // Out-of-range and boundary addresses.
        xact_a(1'b0, 64'h7FFF_FFF8, 64'h0, 8'h00, rd, er, lat);
        check("oor_lo_data", rd, 64'h0);
        check("oor_lo_err", 64'(er), 64'd1);
        xact_a(1'b0, 64'h8000_2000, 64'h0, 8'h00, rd, er, lat);
        check("oor_hi_data", rd, 64'h0);
        check("oor_hi_err", 64'(er), 64'd1);
        xact_a(1'b1, 64'h8000_2000, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, rd, er, lat);
        check("oor_wr_err", 64'(er), 64'd1);
        xact_a(1'b0, 64'h8000_0000, 64'h0, 8'h00, rd, er, lat);
        check("oor_wr_nowrap", rd, 64'h1122_3344_5566_7788);
        xact_a(1'b0, 64'h8000_1FF8, 64'h0, 8'h00, rd, er, lat);
        check("last_word_data", rd, 64'hCAFE_F00D_1234_5678);
        check("last_word_err", 64'(er), 64'd0);

        // Back-pressure with a second request waiting.
        bus_a.resp_ready_i = 1'b0;
        @(negedge clk);
        bus_a.req_valid_i = 1'b1; bus_a.req_we_i = 1'b0; bus_a.req_addr_i = 64'h8000_0000;
        @(posedge clk);
        #1 bus_a.req_addr_i = 64'h8000_1FF8;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (!bus_a.resp_valid_o && guard < 50);
        check("bp_resp_seen", 64'(bus_a.resp_valid_o), 64'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_ready_low", 64'(bus_a.req_ready_o), 64'd0);
            check("bp_valid_held", 64'(bus_a.resp_valid_o), 64'd1);
            check("bp_rdata_held", bus_a.resp_rdata_o, 64'h1122_3344_5566_7788);
        end
        $display("[TB] xact backpressure read addr=80000000 held 5 cycles");
        bus_a.resp_ready_i = 1'b1;
        @(negedge clk);
        check("bp_release_valid", 64'(bus_a.resp_valid_o), 64'd0);
        check("bp_release_ready", 64'(bus_a.req_ready_o), 64'd1);
        @(posedge clk);
        #1 bus_a.req_valid_i = 1'b0;
        check("bp_next_accepted", 64'(bus_a.req_ready_o), 64'd0);
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (!bus_a.resp_valid_o && guard < 50);
        check("bp_next_lat", 64'(guard), 64'd3);
        check("bp_next_data", bus_a.resp_rdata_o, 64'hCAFE_F00D_1234_5678);
        $display("[TB] xact read addr=80001ff8 -> rdata=%h", bus_a.resp_rdata_o);
        @(posedge clk);
        #1;

        // Zero-latency streaming.
        @(negedge clk);
        prev_cyc = 0;
        for (int k = 0; k < 4; k++) begin
            bus_b.req_valid_i = 1'b1; bus_b.req_we_i = 1'b0;
            bus_b.req_addr_i  = 64'h8000_0000 + 64'(8 * k);
            guard = 0;
            while (!bus_b.req_ready_o && guard < 50) begin
                @(negedge clk);
                guard++;
            end
            acc_cyc = cyc;
            @(posedge clk);
            @(negedge clk);
            check("l0_valid", 64'(bus_b.resp_valid_o), 64'd1);
            check("l0_data", bus_b.resp_rdata_o, bexp[k]);
            if (k > 0) check("l0_spacing", 64'(acc_cyc - prev_cyc), 64'd2);
            $display("[TB] xact l0 read addr=%h -> rdata=%h", bus_b.req_addr_i, bus_b.resp_rdata_o);
            prev_cyc = acc_cyc;
        end
        bus_b.req_valid_i = 1'b0;

        // Reset during the wait phase of a write.
        @(negedge clk);
        bus_a.req_valid_i = 1'b1; bus_a.req_we_i = 1'b1; bus_a.req_addr_i = 64'h8000_0028;
        bus_a.req_wdata_i = 64'hDEAD; bus_a.req_wmask_i = 8'hFF;
        @(posedge clk);
        #1 bus_a.req_valid_i = 1'b0;
        check("mid_in_wait", 64'(bus_a.req_ready_o), 64'd0);
        @(negedge clk);
        #1 rst = 1'b0;
        #1;
        check("mid_rst_ready", 64'(bus_a.req_ready_o), 64'd1);
        check("mid_rst_valid", 64'(bus_a.resp_valid_o), 64'd0);
        check("mid_rst_rdata", bus_a.resp_rdata_o, 64'd0);
        check("mid_rst_err", 64'(bus_a.resp_err_o), 64'd0);
        $display("[TB] xact write addr=80000028 dropped by reset");
        repeat (3) @(negedge clk);
        rst = 1'b1;
        xact_a(1'b0, 64'h8000_0028, 64'h0, 8'h00, rd, er, lat);
        check("mid_rst_nocommit", rd, 64'h0);
        check("mid_rst_rd_err", 64'(er), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", n_tests, n_fail);
        $fatal(1);
    end
endmodule
